// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter state type
package uart_pkg;

  localparam int UBRR_DEFAULT = 10415;
  localparam int FRAME_BITS   = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - CPU-side load port and serial/status outputs of uart_tx
interface uart_tx_if;
  import uart_pkg::*;

  logic       Load;
  logic [7:0] Data_in;
  logic       TX;
  logic       Full;
  logic       Busy;
  logic       OE;

  modport master (output Load, Data_in, input TX, Full, Busy, OE);
  modport slave  (input Load, Data_in, output TX, Full, Busy, OE);

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - show-ahead byte FIFO feeding the transmitter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        wr_ok;
  logic        rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok   = rd_en && !empty;
  // A write into a full FIFO is still taken when the head leaves on the same edge.
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_ok) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a small load FIFO
module uart_tx
  import uart_pkg::*;
#(
  parameter int UBRR  = UBRR_DEFAULT,
  parameter int DEPTH = 4
) (
  input logic     Clk,
  input logic     Rst_n,
  uart_tx_if.slave bus
);

  localparam int            CW       = (UBRR > 0) ? $clog2(UBRR + 1) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(UBRR);

  uart_tx_state_t state, state_n;
  logic [CW-1:0]  baud_cnt, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shift, shift_n;
  logic           tx, tx_n;
  logic           oe;
  logic           pop;
  logic           full;
  logic           empty;
  logic           baud_end;
  logic [7:0]     head;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .wr_en   (bus.Load),
    .wr_data (bus.Data_in),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign baud_end = (baud_cnt == BAUD_MAX);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      oe       <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      tx       <= tx_n;
      oe       <= bus.Load && full && !pop;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          tx_n    = shift[0];
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            bit_n   = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.TX   = tx;
  assign bus.Full = full;
  assign bus.Busy = (state != IDLE) || !empty;
  assign bus.OE   = oe;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a frame-level model and line decoder
module tb_uart_tx;
  import uart_pkg::*;

  localparam int UBRR      = 3;
  localparam int DEPTH     = 4;
  localparam int BIT_CYC   = UBRR + 1;
  localparam int FRAME_CYC = FRAME_BITS * BIT_CYC;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  uart_tx_if bus();

  uart_tx #(.UBRR(UBRR), .DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Reference model: a queue of waiting bytes and the remaining cycles of the frame on the line.
  logic [7:0] mq[$];
  logic [7:0] acc_q[$];
  logic [7:0] cur = 8'h00;
  int         rem = 0;
  bit         m_oe = 1'b0;
  bit         m_pop;
  bit         m_acc;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mq.delete();
      rem  = 0;
      m_oe = 1'b0;
    end else begin
      m_pop = (rem <= 1) && (mq.size() > 0);
      m_acc = bus.Load && ((mq.size() < DEPTH) || m_pop);
      m_oe  = bus.Load && !m_acc;
      if (m_pop) begin
        cur = mq.pop_front();
        rem = FRAME_CYC;
      end else if (rem > 0) begin
        rem--;
      end
      if (m_acc) begin
        mq.push_back(bus.Data_in);
        acc_q.push_back(bus.Data_in);
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (rem == 0) return 1'b1;
    k = (FRAME_CYC - rem) / BIT_CYC;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  // Independent line decoder: samples mid-bit, keeps received bytes and start cycles.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         rx_on  = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh  = 8'h00;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (bus.TX === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
        rx_t.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt > BIT_CYC && rx_cnt < 9 * BIT_CYC && (rx_cnt % BIT_CYC) == BIT_CYC / 2)
        rx_sh[rx_cnt / BIT_CYC - 1] = bus.TX;
      if (rx_cnt == 9 * BIT_CYC + BIT_CYC / 2) begin
        rx_on = 1'b0;
        if (bus.TX === 1'b1) rx_q.push_back(rx_sh);
        else rx_q.push_back(~rx_sh);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (bus.Busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    ok = (bus.Busy === 1'b0);
  endtask

  task automatic test_reset();
    bus.Load    = 1'b0;
    bus.Data_in = 8'h00;
    Rst_n       = 1'b0;
    repeat (3) tick();
    checks++; if (bus.TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.TX); end
    checks++; if (bus.Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.Full); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    checks++; if (bus.OE !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", bus.OE); end
    Rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (bus.TX !== 1'b1) begin errors++; $display("FAIL post_reset_tx: got %b want 1", bus.TX); end
  endtask

  task automatic test_single_latency();
    logic [9:0] pat;
    bit ok;
    pat = {1'b1, 8'hA5, 1'b0};
    rx_q.delete();
    bus.Load = 1'b1; bus.Data_in = 8'hA5;
    tick();
    bus.Load = 1'b0;
    checks++; if (bus.TX !== 1'b1) begin errors++; $display("FAIL latency_pre: TX got %b want 1", bus.TX); end
    for (int c = 0; c < FRAME_CYC; c++) begin
      tick();
      if (c == 0) begin
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL latency_busy: got %b want 1", bus.Busy); end
      end
      checks++;
      if (bus.TX !== pat[c / BIT_CYC]) begin
        errors++; $display("FAIL single_bit c=%0d: TX got %b want %b", c, bus.TX, pat[c / BIT_CYC]);
      end
    end
    tick();
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", bus.Busy); end
    checks++; if (bus.TX !== 1'b1) begin errors++; $display("FAIL single_idle_tx: got %b want 1", bus.TX); end
    wait_idle(10, ok);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      errors++; $display("FAIL single_rx: got %0d bytes (first %h) want 1 byte a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int busy_drops;
    rx_q.delete(); rx_t.delete();
    busy_drops = 0;
    bus.Load = 1'b1; bus.Data_in = 8'h00; tick();
    bus.Data_in = 8'hFF; tick();
    bus.Load = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYC - 1; i++) begin
      tick();
      if (bus.Busy !== 1'b1) busy_drops++;
    end
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle: Busy still %b after budget", bus.Busy); end
    checks++; if (busy_drops != 0) begin errors++; $display("FAIL b2b_gap: Busy low %0d cycles want 0", busy_drops); end
    checks++;
    if (rx_t.size() != 2) begin
      errors++; $display("FAIL b2b_starts: got %0d start bits want 2", rx_t.size());
    end else if (rx_t[1] - rx_t[0] != FRAME_CYC) begin
      errors++; $display("FAIL b2b_spacing: got %0d cycles want %0d", rx_t[1] - rx_t[0], FRAME_CYC);
    end
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
      errors++; $display("FAIL b2b_rx: got %0d bytes want 00 ff", rx_q.size());
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [7:0] want;
    rx_q.delete();
    bus.Load = 1'b1; bus.Data_in = 8'h10; tick();
    bus.Load = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 5; i++) begin
      bus.Load = 1'b1; bus.Data_in = 8'h11 + 8'(i);
      tick();
      if (i == 3) begin
        checks++; if (bus.Full !== 1'b1) begin errors++; $display("FAIL ovr_full: got %b want 1", bus.Full); end
        checks++; if (bus.OE !== 1'b0) begin errors++; $display("FAIL ovr_oe_early: got %b want 0", bus.OE); end
      end
    end
    bus.Load = 1'b0;
    checks++; if (bus.OE !== 1'b1) begin errors++; $display("FAIL ovr_oe_pulse: got %b want 1", bus.OE); end
    tick();
    checks++; if (bus.OE !== 1'b0) begin errors++; $display("FAIL ovr_oe_width: got %b want 0", bus.OE); end
    wait_idle(6 * FRAME_CYC, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_idle: Busy still %b after budget", bus.Busy); end
    checks++;
    if (rx_q.size() != 5) begin
      errors++; $display("FAIL ovr_count: got %0d frames want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        want = 8'h10 + 8'(i);
        if (rx_q[i] !== want) begin
          errors++; $display("FAIL ovr_byte%0d: got %h want %h", i, rx_q[i], want);
          break;
        end
      end
    end
  endtask

  task automatic test_full_pop();
    bit ok;
    int n;
    logic [7:0] want;
    rx_q.delete();
    bus.Load = 1'b1; bus.Data_in = 8'h21; tick();
    bus.Load = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      bus.Load = 1'b1; bus.Data_in = 8'h22 + 8'(i); tick();
    end
    bus.Load = 1'b0;
    n = 0;
    while (rem != 1 && n < 2 * FRAME_CYC) begin
      tick();
      n++;
    end
    checks++; if (bus.Full !== 1'b1) begin errors++; $display("FAIL fp_full_before: got %b want 1", bus.Full); end
    bus.Load = 1'b1; bus.Data_in = 8'h26; tick();
    bus.Load = 1'b0;
    checks++; if (bus.OE !== 1'b0) begin errors++; $display("FAIL fp_oe: got %b want 0", bus.OE); end
    checks++; if (bus.Full !== 1'b1) begin errors++; $display("FAIL fp_full_after: got %b want 1", bus.Full); end
    wait_idle(7 * FRAME_CYC, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fp_idle: Busy still %b after budget", bus.Busy); end
    checks++;
    if (rx_q.size() != 6) begin
      errors++; $display("FAIL fp_count: got %0d frames want 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        want = 8'h21 + 8'(i);
        if (rx_q[i] !== want) begin
          errors++; $display("FAIL fp_byte%0d: got %h want %h", i, rx_q[i], want);
          break;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rx_q.delete();
    bus.Load = 1'b1; bus.Data_in = 8'h5A; tick();
    bus.Load = 1'b0;
    repeat (1 + 4 * BIT_CYC + 1) tick();
    #1 Rst_n = 1'b0;
    #1;
    checks++; if (bus.TX !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", bus.TX); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.Busy); end
    repeat (3) tick();
    Rst_n = 1'b1;
    tick();
    bus.Load = 1'b1; bus.Data_in = 8'h3C; tick();
    bus.Load = 1'b0;
    wait_idle(2 * FRAME_CYC, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_idle: Busy still %b after budget", bus.Busy); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      errors++; $display("FAIL rstmid_rx: got %0d bytes (first %h) want 1 byte 3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    bit ok;
    int rate;
    acc_q.delete(); rx_q.delete();
    for (int i = 0; i < 600; i++) begin
      rate = (i < 300) ? 6 : 50;
      bus.Load    = ($urandom_range(0, rate - 1) == 0);
      bus.Data_in = 8'($urandom);
      tick();
      checks++; if (bus.TX !== exp_tx()) begin errors++; $display("FAIL rand_tx i=%0d: got %b want %b", i, bus.TX, exp_tx()); end
      checks++;
      if (bus.Busy !== ((rem > 0) || (mq.size() > 0))) begin
        errors++; $display("FAIL rand_busy i=%0d: got %b want %b", i, bus.Busy, (rem > 0) || (mq.size() > 0));
      end
      checks++;
      if (bus.Full !== (mq.size() == DEPTH)) begin
        errors++; $display("FAIL rand_full i=%0d: got %b want %b", i, bus.Full, mq.size() == DEPTH);
      end
      checks++; if (bus.OE !== m_oe) begin errors++; $display("FAIL rand_oe i=%0d: got %b want %b", i, bus.OE, m_oe); end
    end
    bus.Load = 1'b0;
    wait_idle(8 * FRAME_CYC, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_idle: Busy still %b after budget", bus.Busy); end
    checks++;
    if (rx_q.size() != acc_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d frames want %0d", rx_q.size(), acc_q.size());
    end else begin
      for (int i = 0; i < acc_q.size(); i++) begin
        if (rx_q[i] !== acc_q[i]) begin
          errors++; $display("FAIL rand_byte%0d: got %h want %h", i, rx_q[i], acc_q[i]);
          break;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
